// File: rtl/mem_sequencer.sv
// Sequences instruction fetch and data access over one shared memory bus (FETCH/EXEC/DATA/WB/HALT).
// Define MEM_SEQ_TIMEOUT_EN to abandon bus transactions that stay busy for TIMEOUT_CYC cycles.
module mem_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] PCaddr,
    input  logic        dren,
    input  logic        dwen,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dsel,
    input  logic        halt,
    input  logic        mem_busy,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [3:0]  mem_sel,
    output logic [31:0] instr,
    output logic [31:0] dmem_rdata,
    output logic        iready,
    output logic        dready,
    output logic        halted,
    output logic        bus_err
);

    typedef enum logic [2:0] {FETCH, EXEC, DATA, WB, HALT} state_t;

    state_t      state_reg, state_next;
    logic [31:0] instr_reg, dmem_rdata_reg;
    logic        halted_reg;
    logic        timeout_hit;

    logic fetch_done, data_done, data_read, in_bus_state;
    assign in_bus_state = (state_reg == FETCH) || (state_reg == DATA);
    assign fetch_done   = (state_reg == FETCH) && !mem_busy;
    assign data_done    = (state_reg == DATA) && !mem_busy;
    assign data_read    = dren & ~dwen;

    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

`ifdef MEM_SEQ_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CNT_W-1:0] cnt_reg;
    logic             bus_err_reg;

    // Fires on the edge where the busy count would reach TIMEOUT_CYC.
    assign timeout_hit = in_bus_state && mem_busy && (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!nRST) begin
            cnt_reg     <= '0;
            bus_err_reg <= 1'b0;
        end else begin
            if (state_next != state_reg)
                cnt_reg <= '0;
            else if (in_bus_state && mem_busy)
                cnt_reg <= cnt_reg + 1'b1;
            if (timeout_hit)
                bus_err_reg <= 1'b1;
        end
    end

    assign bus_err = bus_err_reg;
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH: if (timeout_hit) state_next = HALT;
                   else if (!mem_busy) state_next = EXEC;
            EXEC:  if (halt) state_next = HALT;
                   else if (dren || dwen) state_next = DATA;
                   else state_next = FETCH;
            DATA:  if (timeout_hit) state_next = HALT;
                   else if (!mem_busy) state_next = WB;
            WB:    state_next = FETCH;
            HALT:  state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // Bus strobes and handshakes are decoded from state; reset masks them all.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_sel   = '0;
        iready    = 1'b0;
        dready    = 1'b0;
        if (nRST) begin
            case (state_reg)
                FETCH: begin
                    mem_ren  = 1'b1;
                    mem_addr = PCaddr;
                    mem_sel  = 4'hF;
                end
                EXEC: iready = !halt && !(dren || dwen);
                DATA: begin
                    mem_addr  = daddr;
                    mem_sel   = dsel;
                    mem_wdata = dwdata;
                    mem_wen   = dwen;
                    mem_ren   = data_read;
                end
                WB: begin
                    iready = 1'b1;
                    dready = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_reg      <= FETCH;
            instr_reg      <= '0;
            dmem_rdata_reg <= '0;
            halted_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (fetch_done)
                instr_reg <= mem_rdata;
            if (data_done && data_read)
                dmem_rdata_reg <= mem_rdata;
            if (state_next == HALT)
                halted_reg <= 1'b1;
        end
    end

    assign instr      = instr_reg;
    assign dmem_rdata = dmem_rdata_reg;
    assign halted     = halted_reg;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer: fetch cadence, load, store, bus stalls, halt, reset and stuck bus.
module tb_mem_sequencer;

    logic        clk = 1'b0;
    logic        nRST;
    logic [31:0] PCaddr, daddr, dwdata, mem_rdata;
    logic        dren, dwen, halt, mem_busy;
    logic [3:0]  dsel;
    logic [31:0] mem_addr, mem_wdata, instr, dmem_rdata;
    logic        mem_ren, mem_wen, iready, dready, halted, bus_err;
    logic [3:0]  mem_sel;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

`ifdef MEM_SEQ_TIMEOUT_EN
    mem_sequencer #(.TIMEOUT_CYC(4)) dut (
`else
    mem_sequencer dut (
`endif
        .clk(clk), .nRST(nRST), .PCaddr(PCaddr), .dren(dren), .dwen(dwen),
        .daddr(daddr), .dwdata(dwdata), .dsel(dsel), .halt(halt),
        .mem_busy(mem_busy), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_sel(mem_sel), .instr(instr), .dmem_rdata(dmem_rdata),
        .iready(iready), .dready(dready), .halted(halted), .bus_err(bus_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    // Inputs change 1 ns after the edge; outputs are checked 1 ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        nRST = 1'b0; PCaddr = 32'h0; dren = 1'b0; dwen = 1'b0; daddr = 32'h0;
        dwdata = 32'h0; dsel = 4'h0; halt = 1'b0; mem_busy = 1'b0; mem_rdata = 32'h13;
        next_cycle(); next_cycle();
        settle();
        check("rst_ren", {31'b0, mem_ren}, 32'd0);
        check("rst_sel", {28'b0, mem_sel}, 32'd0);
        check("rst_iready", {31'b0, iready}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_dmem", dmem_rdata, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_buserr", {31'b0, bus_err}, 32'd0);

        nRST = 1'b1; settle();
        check("fetch0_ren", {31'b0, mem_ren}, 32'd1);
        check("fetch0_addr", mem_addr, 32'h0);
        check("fetch0_sel", {28'b0, mem_sel}, 32'hF);
        check("fetch0_iready", {31'b0, iready}, 32'd0);
        next_cycle();
        check("exec0_instr", instr, 32'h13);
        check("exec0_iready", {31'b0, iready}, 32'd1);
        check("exec0_ren", {31'b0, mem_ren}, 32'd0);
        next_cycle();
        PCaddr = 32'h4; mem_rdata = 32'h93; settle();
        check("fetch1_iready", {31'b0, iready}, 32'd0);
        check("fetch1_addr", mem_addr, 32'h4);

        // Load from 0x100.
        next_cycle();
        dren = 1'b1; daddr = 32'h100; dsel = 4'hF; settle();
        check("ld_exec_instr", instr, 32'h93);
        check("ld_exec_iready", {31'b0, iready}, 32'd0);
        next_cycle();
        mem_rdata = 32'hDEADBEEF; settle();
        check("ld_data_ren", {31'b0, mem_ren}, 32'd1);
        check("ld_data_wen", {31'b0, mem_wen}, 32'd0);
        check("ld_data_addr", mem_addr, 32'h100);
        next_cycle();
        dren = 1'b0; mem_rdata = 32'h13; settle();
        check("ld_wb_dmem", dmem_rdata, 32'hDEADBEEF);
        check("ld_wb_iready", {31'b0, iready}, 32'd1);
        check("ld_wb_dready", {31'b0, dready}, 32'd1);
        check("ld_wb_addr", mem_addr, 32'h0);
        next_cycle();
        check("ld_refetch_ren", {31'b0, mem_ren}, 32'd1);
        check("ld_refetch_dready", {31'b0, dready}, 32'd0);

        // Both requests set: write wins.
        next_cycle();
        dren = 1'b1; dwen = 1'b1; dwdata = 32'h12345678; dsel = 4'b0011; daddr = 32'h200;
        next_cycle();
        mem_rdata = 32'hCAFEF00D; settle();
        check("st_data_wen", {31'b0, mem_wen}, 32'd1);
        check("st_data_ren", {31'b0, mem_ren}, 32'd0);
        check("st_data_sel", {28'b0, mem_sel}, 32'h3);
        check("st_data_wdata", mem_wdata, 32'h12345678);
        check("st_data_addr", mem_addr, 32'h200);
        next_cycle();
        dren = 1'b0; dwen = 1'b0; mem_rdata = 32'h13; settle();
        check("st_wb_dmem", dmem_rdata, 32'hDEADBEEF);
        check("st_wb_dready", {31'b0, dready}, 32'd1);
        check("st_wb_wen", {31'b0, mem_wen}, 32'd0);

        // Five busy cycles in FETCH, completion on the sixth.
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            mem_busy = 1'b1; mem_rdata = 32'h0000AAAA + i; settle();
            check($sformatf("stall%0d_ren", i), {31'b0, mem_ren}, 32'd1);
            check($sformatf("stall%0d_iready", i), {31'b0, iready}, 32'd0);
            next_cycle();
        end
        check("stall_instr_held", instr, 32'h13);
        mem_busy = 1'b0; mem_rdata = 32'h00500513; settle();
        check("stall6_ren", {31'b0, mem_ren}, 32'd1);
        next_cycle();
        check("stall_instr", instr, 32'h00500513);
        check("stall_exec_iready", {31'b0, iready}, 32'd1);

        // Halt beats a simultaneous load request.
        next_cycle();
        next_cycle();
        halt = 1'b1; dren = 1'b1; settle();
        check("halt_exec_iready", {31'b0, iready}, 32'd0);
        next_cycle();
        halt = 1'b0; dren = 1'b0; settle();
        check("halt_halted", {31'b0, halted}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("halt%0d_ren", i), {31'b0, mem_ren}, 32'd0);
            check($sformatf("halt%0d_iready", i), {31'b0, iready}, 32'd0);
            next_cycle();
        end
        check("halt_sticky", {31'b0, halted}, 32'd1);
        nRST = 1'b0;
        next_cycle();
        nRST = 1'b1; PCaddr = 32'h40; settle();
        check("unhalt_halted", {31'b0, halted}, 32'd0);
        check("unhalt_ren", {31'b0, mem_ren}, 32'd1);
        check("unhalt_addr", mem_addr, 32'h40);

        // Reset in the middle of a stalled fetch.
        mem_busy = 1'b1; mem_rdata = 32'h11111111;
        next_cycle();
        nRST = 1'b0; settle();
        check("midrst_ren", {31'b0, mem_ren}, 32'd0);
        check("midrst_sel", {28'b0, mem_sel}, 32'd0);
        next_cycle();
        nRST = 1'b1; mem_busy = 1'b0; mem_rdata = 32'h22222222; settle();
        check("midrst_instr", instr, 32'h0);
        check("midrst_refetch", {31'b0, mem_ren}, 32'd1);
        next_cycle();
        check("midrst_newinstr", instr, 32'h22222222);

        // Bus stuck busy from a fresh FETCH.
        next_cycle();
        mem_busy = 1'b1;
`ifdef MEM_SEQ_TIMEOUT_EN
        for (int i = 0; i < 3; i++) next_cycle();
        check("to_before_err", {31'b0, bus_err}, 32'd0);
        check("to_before_ren", {31'b0, mem_ren}, 32'd1);
        next_cycle();
        check("to_buserr", {31'b0, bus_err}, 32'd1);
        check("to_halted", {31'b0, halted}, 32'd1);
        check("to_ren", {31'b0, mem_ren}, 32'd0);
        check("to_instr", instr, 32'h22222222);
`else
        for (int i = 0; i < 1000; i++) next_cycle();
        check("stuck_ren", {31'b0, mem_ren}, 32'd1);
        check("stuck_iready", {31'b0, iready}, 32'd0);
        check("stuck_buserr", {31'b0, bus_err}, 32'd0);
        check("stuck_halted", {31'b0, halted}, 32'd0);
        check("stuck_instr", instr, 32'h22222222);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
